// File: rtl/vga_fb_ctrl.sv
// 320x240 RGB444 framebuffer feeding the VGA controller, pixel-doubled to 640x480.
// Single-clock pixel write port plus a hardware clear-screen engine.
module vga_fb_ctrl #(
   parameter int FB_W  = 320,
   parameter int FB_H  = 240,
   parameter int H_RES = 640,
   parameter int V_RES = 480
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [9:0]  h_addr,
   input  logic [9:0]  v_addr,
   output logic [23:0] vga_data,
   input  logic        wr_valid,
   output logic        wr_ready,
   input  logic [8:0]  wr_x,
   input  logic [7:0]  wr_y,
   input  logic [11:0] wr_color,
   input  logic        clr_req,
   input  logic [11:0] clr_color,
   output logic        busy
);

   localparam int AW   = 17;
   localparam int NPIX = FB_W * FB_H;
   localparam logic [AW-1:0] LAST = AW'(NPIX - 1);

   typedef enum logic {
      IDLE,
      CLEAR
   } state_t;

   // y*FB_W built from shifted copies of y; for 320 this is (y<<8)+(y<<6)
   function automatic logic [AW-1:0] lin_addr(
      input logic [8:0] y,
      input logic [8:0] x
   );
      logic [AW-1:0] acc;
      acc = AW'(x);
      for (int i = 0; i < AW; i++) begin
         if (FB_W[i]) acc = acc + (AW'(y) << i);
      end
      return acc;
   endfunction

   logic [11:0]   mem [NPIX];

   state_t        state_q, state_d;
   logic [AW-1:0] ptr_q, ptr_d;
   logic [11:0]   color_q, color_d;
   logic          blank_q, blank_d;
   logic [11:0]   rd_data_q;

   logic          rd_in;
   logic [AW-1:0] rd_addr;
   logic          wr_in;
   logic          mem_we;
   logic [AW-1:0] mem_waddr;
   logic [11:0]   mem_wdata;
   logic          unused_lsb;

   assign unused_lsb = ^{h_addr[0], v_addr[0]};

   always_comb begin
      rd_in   = (32'(h_addr) < H_RES) && (32'(v_addr) < V_RES);
      rd_addr = '0;
      if (rd_in) rd_addr = lin_addr(v_addr[9:1], h_addr[9:1]);
      blank_d = !rd_in;
   end

   always_comb begin
      wr_in     = (32'(wr_x) < FB_W) && (32'(wr_y) < FB_H);
      state_d   = state_q;
      ptr_d     = ptr_q;
      color_d   = color_q;
      mem_we    = 1'b0;
      mem_waddr = lin_addr({1'b0, wr_y}, wr_x);
      mem_wdata = wr_color;
      unique case (state_q)
         IDLE: begin
            mem_we = wr_valid && wr_in;
            if (clr_req) begin
               state_d = CLEAR;
               ptr_d   = '0;
               color_d = clr_color;
            end
         end
         CLEAR: begin
            mem_we    = 1'b1;
            mem_waddr = ptr_q;
            mem_wdata = color_q;
            if (ptr_q == LAST) begin
               state_d = IDLE;
               ptr_d   = '0;
            end else begin
               ptr_d = ptr_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      // nothing may land in memory while reset is held
      mem_we = mem_we && reset;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         color_q <= '0;
         blank_q <= 1'b1;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         color_q <= color_d;
         blank_q <= blank_d;
      end
   end

   // plain RAM: read-before-write gives old data on a same-address collision
   always_ff @(posedge clock) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
      rd_data_q <= mem[rd_addr];
   end

   always_comb begin
      vga_data = '0;
      if (!blank_q) begin
         vga_data = {rd_data_q[11:8], rd_data_q[11:8],
                     rd_data_q[7:4],  rd_data_q[7:4],
                     rd_data_q[3:0],  rd_data_q[3:0]};
      end
   end

   assign wr_ready = (state_q == IDLE);
   assign busy     = (state_q == CLEAR);

endmodule

// File: tb/tb_vga_fb_ctrl.sv
// Randomized bench for vga_fb_ctrl against an array model of the framebuffer.
// Uses a short framebuffer (320x8) so full clears and frame reads stay quick.
`timescale 1ns/1ps
module tb_vga_fb_ctrl;

   localparam int FB_W  = 320;
   localparam int FB_H  = 8;
   localparam int H_RES = 640;
   localparam int V_RES = 16;
   localparam int NPIX  = FB_W * FB_H;

   logic        clock;
   logic        reset;
   logic [9:0]  h_addr;
   logic [9:0]  v_addr;
   logic [23:0] vga_data;
   logic        wr_valid;
   logic        wr_ready;
   logic [8:0]  wr_x;
   logic [7:0]  wr_y;
   logic [11:0] wr_color;
   logic        clr_req;
   logic [11:0] clr_color;
   logic        busy;

   vga_fb_ctrl #(
      .FB_W (FB_W),
      .FB_H (FB_H),
      .H_RES(H_RES),
      .V_RES(V_RES)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .h_addr   (h_addr),
      .v_addr   (v_addr),
      .vga_data (vga_data),
      .wr_valid (wr_valid),
      .wr_ready (wr_ready),
      .wr_x     (wr_x),
      .wr_y     (wr_y),
      .wr_color (wr_color),
      .clr_req  (clr_req),
      .clr_color(clr_color),
      .busy     (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #3000000;
      $display("FAIL watchdog: sim time exceeded, required finish earlier");
      $fatal(1, "watchdog");
   end

   logic [11:0] model [NPIX];
   logic [23:0] rb [NPIX];
   int n_cmp;
   int n_bad;

   function automatic logic [23:0] exp_c(input logic [11:0] c);
      logic [7:0] r, g, b;
      r = 8'(c[11:8] * 17);
      g = 8'(c[7:4] * 17);
      b = 8'(c[3:0] * 17);
      return {r, g, b};
   endfunction

   function automatic logic [23:0] model_px(input int h, input int v);
      if (h >= H_RES || v >= V_RES) return 24'h000000;
      return exp_c(model[(v / 2) * FB_W + h / 2]);
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic read_px(input int h, input int v, output logic [23:0] d);
      h_addr = 10'(h);
      v_addr = 10'(v);
      step();
      d = vga_data;
   endtask

   task automatic write_px(input int x, input int y, input logic [11:0] c);
      wr_x     = 9'(x);
      wr_y     = 8'(y);
      wr_color = c;
      wr_valid = 1'b1;
      step();
      wr_valid = 1'b0;
      if (x < FB_W && y < FB_H) model[y * FB_W + x] = c;
   endtask

   task automatic read_frame();
      for (int a = 0; a < NPIX; a++) begin
         read_px(2 * (a % FB_W) + int'($urandom_range(0, 1)),
                 2 * (a / FB_W) + int'($urandom_range(0, 1)), rb[a]);
      end
   endtask

   task automatic run_clear(input logic [11:0] c, input bit mid_pulse,
                            output int cycles, output int rdy_bad);
      clr_color = c;
      clr_req   = 1'b1;
      step();
      clr_req  = 1'b0;
      wr_valid = 1'b0;
      cycles   = 0;
      rdy_bad  = 0;
      while (busy === 1'b1 && cycles < NPIX + 50) begin
         cycles++;
         if (wr_ready !== 1'b0) rdy_bad++;
         if (mid_pulse) begin
            clr_req   = (cycles == 100);
            clr_color = 12'hF0F;
         end
         step();
      end
      clr_req = 1'b0;
      for (int a = 0; a < NPIX; a++) model[a] = c;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      n_cmp++;
      if (vga_data !== 24'h0) begin
         n_bad++;
         $display("FAIL reset_vga_data: got %h want 000000", vga_data);
      end
      n_cmp++;
      if (busy !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_busy: got %b want 0", busy);
      end
      reset = 1'b1;
      step();
      n_cmp++;
      if (wr_ready !== 1'b1 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL after_reset_ready: ready %b busy %b want 1 0", wr_ready, busy);
      end
   endtask

   task automatic test_clear();
      int cyc, rbad, bad, first;
      run_clear(12'h00F, 1'b1, cyc, rbad);
      n_cmp++;
      if (cyc !== NPIX) begin
         n_bad++;
         $display("FAIL clear_cycles: got %0d want %0d", cyc, NPIX);
      end
      n_cmp++;
      if (rbad !== 0) begin
         n_bad++;
         $display("FAIL clear_ready_low: %0d cycles with ready high, want 0", rbad);
      end
      n_cmp++;
      if (busy !== 1'b0 || wr_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL clear_end: busy %b ready %b want 0 1", busy, wr_ready);
      end
      read_frame();
      bad = 0;
      first = -1;
      for (int a = 0; a < NPIX; a++) begin
         if (rb[a] !== 24'h0000FF) begin
            bad++;
            if (first < 0) first = a;
         end
      end
      n_cmp++;
      if (bad != 0) begin
         n_bad++;
         $display("FAIL clear_frame: %0d bad, addr %0d got %h want 0000ff",
                  bad, first, rb[first]);
      end
   endtask

   task automatic test_basic();
      logic [23:0] d;
      n_cmp++;
      if (wr_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL basic_ready: got %b want 1", wr_ready);
      end
      write_px(5, 3, 12'hF80);
      read_px(10, 6, d);
      n_cmp++;
      if (d !== 24'hFF8800) begin
         n_bad++;
         $display("FAIL basic_read_10_6: got %h want ff8800", d);
      end
      read_px(11, 7, d);
      n_cmp++;
      if (d !== 24'hFF8800) begin
         n_bad++;
         $display("FAIL basic_read_11_7: got %h want ff8800", d);
      end
      read_px(12, 6, d);
      n_cmp++;
      if (d !== 24'h0000FF) begin
         n_bad++;
         $display("FAIL basic_neighbour: got %h want 0000ff", d);
      end
   endtask

   task automatic test_out_of_range();
      logic [23:0] d;
      write_px(FB_W - 1, FB_H - 1, 12'h3C7);
      read_px(H_RES - 1, V_RES - 1, d);
      n_cmp++;
      if (d !== model_px(H_RES - 1, V_RES - 1)) begin
         n_bad++;
         $display("FAIL oor_last_pixel: got %h want %h", d, model_px(H_RES - 1, V_RES - 1));
      end
      read_px(H_RES, 0, d);
      n_cmp++;
      if (d !== 24'h0) begin
         n_bad++;
         $display("FAIL oor_h640: got %h want 000000", d);
      end
      read_px(0, V_RES, d);
      n_cmp++;
      if (d !== 24'h0) begin
         n_bad++;
         $display("FAIL oor_v_res: got %h want 000000", d);
      end
      read_px(0, 480, d);
      n_cmp++;
      if (d !== 24'h0) begin
         n_bad++;
         $display("FAIL oor_v480: got %h want 000000", d);
      end
   endtask

   task automatic test_dropped_write();
      int bad, first;
      write_px(FB_W, 2, 12'hFFF);
      n_cmp++;
      if (wr_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL drop_ready: got %b want 1", wr_ready);
      end
      write_px(7, FB_H, 12'hFFF);
      write_px(511, 255, 12'hFFF);
      read_frame();
      bad = 0;
      first = -1;
      for (int a = 0; a < NPIX; a++) begin
         if (rb[a] !== exp_c(model[a])) begin
            bad++;
            if (first < 0) first = a;
         end
      end
      n_cmp++;
      if (bad != 0) begin
         n_bad++;
         $display("FAIL drop_frame: %0d bad, addr %0d got %h want %h",
                  bad, first, rb[first], exp_c(model[first]));
      end
   endtask

   task automatic test_random();
      logic [23:0] d;
      int h, v;
      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 3) == 0) step();
         n_cmp++;
         if (wr_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL rand_ready %0d: got %b want 1", i, wr_ready);
         end
         write_px(int'($urandom_range(0, FB_W + 20)), int'($urandom_range(0, FB_H + 1)),
                  12'($urandom));
      end
      for (int i = 0; i < 200; i++) begin
         h = int'($urandom_range(0, H_RES + 60));
         v = int'($urandom_range(0, V_RES + 3));
         read_px(h, v, d);
         n_cmp++;
         if (d !== model_px(h, v)) begin
            n_bad++;
            $display("FAIL rand_read h=%0d v=%0d: got %h want %h", h, v, d, model_px(h, v));
         end
      end
   endtask

   task automatic test_collision();
      int x, y;
      logic [11:0] oldc, newc;
      for (int i = 0; i < 3; i++) begin
         x = int'($urandom_range(0, FB_W - 1));
         y = int'($urandom_range(0, FB_H - 1));
         oldc = model[y * FB_W + x];
         newc = ~oldc;
         h_addr   = 10'(2 * x);
         v_addr   = 10'(2 * y + 1);
         wr_x     = 9'(x);
         wr_y     = 8'(y);
         wr_color = newc;
         wr_valid = 1'b1;
         step();
         wr_valid = 1'b0;
         model[y * FB_W + x] = newc;
         n_cmp++;
         if (vga_data !== exp_c(oldc)) begin
            n_bad++;
            $display("FAIL collision_old: got %h want %h", vga_data, exp_c(oldc));
         end
         step();
         n_cmp++;
         if (vga_data !== exp_c(newc)) begin
            n_bad++;
            $display("FAIL collision_new: got %h want %h", vga_data, exp_c(newc));
         end
      end
   endtask

   task automatic test_simultaneous();
      int cyc, rbad;
      logic [23:0] d;
      wr_x     = 9'd0;
      wr_y     = 8'd0;
      wr_color = 12'hF00;
      wr_valid = 1'b1;
      run_clear(12'h0F0, 1'b0, cyc, rbad);
      n_cmp++;
      if (cyc !== NPIX) begin
         n_bad++;
         $display("FAIL simul_cycles: got %0d want %0d", cyc, NPIX);
      end
      read_px(0, 0, d);
      n_cmp++;
      if (d !== 24'h00FF00) begin
         n_bad++;
         $display("FAIL simul_origin: got %h want 00ff00", d);
      end
   endtask

   task automatic test_reset_mid_clear();
      int bad, first;
      logic [23:0] d;
      write_px(40, 3, 12'hABC);
      clr_color = 12'h5A5;
      clr_req   = 1'b1;
      step();
      clr_req = 1'b0;
      repeat (1000) step();
      n_cmp++;
      if (busy !== 1'b1) begin
         n_bad++;
         $display("FAIL midclr_busy_before: got %b want 1", busy);
      end
      reset = 1'b0;
      #1;
      n_cmp++;
      if (busy !== 1'b0 || vga_data !== 24'h0) begin
         n_bad++;
         $display("FAIL midclr_async: busy %b data %h want 0 000000", busy, vga_data);
      end
      wr_x     = 9'd1;
      wr_y     = 8'd7;
      wr_color = 12'h123;
      wr_valid = 1'b1;
      repeat (3) step();
      wr_valid = 1'b0;
      #2;
      reset = 1'b1;
      step();
      n_cmp++;
      if (busy !== 1'b0 || wr_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL midclr_release: busy %b ready %b want 0 1", busy, wr_ready);
      end
      for (int a = 0; a < 1000; a++) model[a] = 12'h5A5;
      read_px(80, 6, d);
      n_cmp++;
      if (d !== exp_c(12'hABC)) begin
         n_bad++;
         $display("FAIL midclr_addr1000: got %h want %h", d, exp_c(12'hABC));
      end
      read_px(78, 6, d);
      n_cmp++;
      if (d !== exp_c(12'h5A5)) begin
         n_bad++;
         $display("FAIL midclr_addr999: got %h want %h", d, exp_c(12'h5A5));
      end
      read_frame();
      bad = 0;
      first = -1;
      for (int a = 0; a < NPIX; a++) begin
         if (rb[a] !== exp_c(model[a])) begin
            bad++;
            if (first < 0) first = a;
         end
      end
      n_cmp++;
      if (bad != 0) begin
         n_bad++;
         $display("FAIL midclr_frame: %0d bad, addr %0d got %h want %h",
                  bad, first, rb[first], exp_c(model[first]));
      end
   endtask

   initial begin
      n_cmp     = 0;
      n_bad     = 0;
      reset     = 1'b0;
      h_addr    = '0;
      v_addr    = '0;
      wr_valid  = 1'b0;
      wr_x      = '0;
      wr_y      = '0;
      wr_color  = '0;
      clr_req   = 1'b0;
      clr_color = '0;
      test_reset();
      test_clear();
      test_basic();
      test_out_of_range();
      test_dropped_write();
      test_random();
      test_collision();
      test_simultaneous();
      test_reset_mid_clear();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
